pipeline_control: RTL and testbench

//  Central sequencer for the 5-stage pipeline. Drives per-stage clock enables and the

---
 rtl/riscv_definitions_pkg.sv | 53 +++++
 rtl/pipeline_control_hazard_detect.sv | 40 ++++
 rtl/pipeline_control.sv | 169 ++++++++++++++++
 tb/tb_pipeline_control.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_definitions_pkg.sv
// ---------------------------------------------------------------------------
// riscv_definitions
//   Shared types and defaults for the 5-stage pipeline control path.
//   - regAddr_t       : architectural register index (x0..x31)
//   - pipeState_e     : pipeline sequencer state (RUN / DMEM_WAIT)
//   - pipeCtrl_t      : bundle of per-stage enables, flushes and redirect
//   - DMEM_TIMEOUT_DEF: default data-memory wait limit in cycles
//   - make_ctrl()     : builds a pipeCtrl_t from the common enable pattern
// ---------------------------------------------------------------------------
package riscv_definitions;

    typedef logic [4:0] regAddr_t;

    typedef enum logic {
        RUN       = 1'b0,
        DMEM_WAIT = 1'b1
    } pipeState_e;

    localparam int DMEM_TIMEOUT_DEF = 256;
    localparam int CNT_W_DEF        = 32;

    typedef struct packed {
        logic if_clk_en;
        logic id_clk_en;
        logic ex_clk_en;
        logic mem_clk_en;
        logic wb_clk_en;
        logic pc_redirect;
        logic if_flush;
        logic id_flush;
    } pipeCtrl_t;

    // Every stage behind IF always shares one enable, so a control word is
    // fully described by the IF enable, the enable of the remaining stages,
    // the redirect and the two flushes.
    function automatic pipeCtrl_t make_ctrl(input logic if_en,
                                            input logic back_en,
                                            input logic redirect,
                                            input logic if_fl,
                                            input logic id_fl);
        pipeCtrl_t c;
        c.if_clk_en   = if_en;
        c.id_clk_en   = back_en;
        c.ex_clk_en   = back_en;
        c.mem_clk_en  = back_en;
        c.wb_clk_en   = back_en;
        c.pc_redirect = redirect;
        c.if_flush    = if_fl;
        c.id_flush    = id_fl;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//   Combinational comparator: flags when a register produced by a
//   later-stage instruction is read by the instruction in decode.
//   Kept generic so the forwarding unit can reuse it for other stage pairs.
// Ports
//   rs1_addr  in  regAddr_t  first source register of the consumer
//   rs2_addr  in  regAddr_t  second source register of the consumer
//   rd_addr   in  regAddr_t  destination register of the producer
//   rd_valid  in  1          producer result is of the hazardous kind
//   hazard    out 1          producer writes a non-x0 register the consumer reads
// ---------------------------------------------------------------------------
module hazard_detect
    import riscv_definitions::*;
(
    input  regAddr_t rs1_addr,
    input  regAddr_t rs2_addr,
    input  regAddr_t rd_addr,
    input  logic     rd_valid,
    output logic     hazard
);

    localparam int N_SRC = 2;

    regAddr_t         src_addr [N_SRC];
    logic [N_SRC-1:0] src_match;

    assign src_addr[0] = rs1_addr;
    assign src_addr[1] = rs2_addr;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src_cmp
            assign src_match[gi] = (src_addr[gi] == rd_addr);
        end
    endgenerate

    // x0 is hard-wired to zero, so writing it never creates a dependency.
    assign hazard = rd_valid & (rd_addr != '0) & (|src_match);

endmodule

// File: rtl/pipeline_control.sv
// ---------------------------------------------------------------------------
// pipeline_control
//   Central sequencer for the 5-stage pipeline. Produces the per-stage clock
//   enables, the IF/ID and ID/EX flushes and the PC redirect. Stalls decode on
//   load-use hazards, applies taken-branch redirects from decode, and freezes
//   the whole pipe while data memory is busy, aborting the access after
//   DMEM_TIMEOUT consecutive wait cycles and raising a sticky bus error.
// Parameters
//   DMEM_TIMEOUT  max consecutive wait cycles before a DMEM access is aborted
//   CNT_W         width of the saturating stall counter
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rs1/rs2_addr_id       source registers of the instruction in decode
//   rd0_addr_ex           destination of the instruction in execute
//   data_rd_en_ex         instruction in execute is a load
//   branch_taken          taken-branch decision from decode
//   imem_ready            instruction memory delivers data this cycle
//   dmem_req_mem          load/store active in memory stage
//   dmem_ready            data memory completes the access this cycle
//   if/id/ex/mem/wb_clk_en per-stage register enables
//   pc_redirect           PC loads the jump target at next edge
//   if_flush, id_flush    IF/ID resp. ID/EX register loads a NOP
//   bus_err               sticky: a DMEM access timed out
//   stall_cycles          saturating count of cycles with if_clk_en low
// ---------------------------------------------------------------------------
module pipeline_control
    import riscv_definitions::*;
#(
    parameter int DMEM_TIMEOUT = DMEM_TIMEOUT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  regAddr_t         rs1_addr_id,
    input  regAddr_t         rs2_addr_id,
    input  regAddr_t         rd0_addr_ex,
    input  logic             data_rd_en_ex,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             if_clk_en,
    output logic             id_clk_en,
    output logic             ex_clk_en,
    output logic             mem_clk_en,
    output logic             wb_clk_en,
    output logic             pc_redirect,
    output logic             if_flush,
    output logic             id_flush,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles
);

    // wait_cnt only has to reach DMEM_TIMEOUT-1.
    localparam int WAIT_W = (DMEM_TIMEOUT > 2) ? $clog2(DMEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    pipeState_e        state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              bus_err_reg, bus_err_next;
    logic [CNT_W-1:0]  stall_reg;

    logic      load_use;
    logic      dmem_miss;
    logic      timeout_hit;
    logic      freeze;
    pipeCtrl_t ctrl;

    hazard_detect u_hazard_detect (
        .rs1_addr (rs1_addr_id),
        .rs2_addr (rs2_addr_id),
        .rd_addr  (rd0_addr_ex),
        .rd_valid (data_rd_en_ex),
        .hazard   (load_use)
    );

    assign dmem_miss   = dmem_req_mem & ~dmem_ready;
    // A completing access wins over the timeout in the same cycle.
    assign timeout_hit = (state_reg == DMEM_WAIT) & (wait_cnt_reg == WAIT_LAST) & dmem_miss;
    assign freeze      = dmem_miss & ~timeout_hit;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
            bus_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            bus_err_reg  <= bus_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        bus_err_next  = bus_err_reg;
        unique case (state_reg)
            RUN: begin
                if (dmem_miss) begin
                    state_next    = DMEM_WAIT;
                    wait_cnt_next = WAIT_ONE;
                end
            end
            DMEM_WAIT: begin
                // A withdrawn request leaves nothing to wait for.
                if (dmem_ready || !dmem_req_mem) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (timeout_hit) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                    bus_err_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_ONE;
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------ control word
    // Rows are mutually exclusive by priority: memory freeze, load-use
    // bubble, branch redirect, instruction fetch miss, normal flow.
    always_comb begin
        ctrl = make_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        if (!rst_n) begin
            ctrl = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (freeze) begin
            ctrl = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (load_use) begin
            // Branch decision is dropped; decode re-evaluates it next cycle.
            ctrl = make_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        end else if (branch_taken) begin
            // Redirect proceeds even without fetch data: the fetched word
            // is flushed anyway.
            ctrl = make_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        end else if (!imem_ready) begin
            ctrl = make_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        end
    end

    assign if_clk_en   = ctrl.if_clk_en;
    assign id_clk_en   = ctrl.id_clk_en;
    assign ex_clk_en   = ctrl.ex_clk_en;
    assign mem_clk_en  = ctrl.mem_clk_en;
    assign wb_clk_en   = ctrl.wb_clk_en;
    assign pc_redirect = ctrl.pc_redirect;
    assign if_flush    = ctrl.if_flush;
    assign id_flush    = ctrl.id_flush;

    // ---------------------------------------------------- stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_reg <= '0;
        end else if (!ctrl.if_clk_en && !(&stall_reg)) begin
            stall_reg <= stall_reg + CNT_W'(1);
        end
    end

    assign bus_err      = bus_err_reg;
    assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_pipeline_control.sv
// ---------------------------------------------------------------------------
// tb_pipeline_control
//   Directed scenarios followed by constrained-random traffic, every cycle
//   compared against a behavioural model of the pipeline sequencer.
// ---------------------------------------------------------------------------
module tb_pipeline_control;

    localparam int TIMEOUT = 4;
    localparam int CW      = 6;
    localparam int CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    rs1_addr_id = '0, rs2_addr_id = '0, rd0_addr_ex = '0;
    logic          data_rd_en_ex = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0;
    logic          dmem_req_mem = 1'b0, dmem_ready = 1'b0;
    logic          if_clk_en, id_clk_en, ex_clk_en, mem_clk_en, wb_clk_en;
    logic          pc_redirect, if_flush, id_flush, bus_err;
    logic [CW-1:0] stall_cycles;

    pipeline_control #(.DMEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs1_addr_id   (rs1_addr_id),
        .rs2_addr_id   (rs2_addr_id),
        .rd0_addr_ex   (rd0_addr_ex),
        .data_rd_en_ex (data_rd_en_ex),
        .branch_taken  (branch_taken),
        .imem_ready    (imem_ready),
        .dmem_req_mem  (dmem_req_mem),
        .dmem_ready    (dmem_ready),
        .if_clk_en     (if_clk_en),
        .id_clk_en     (id_clk_en),
        .ex_clk_en     (ex_clk_en),
        .mem_clk_en    (mem_clk_en),
        .wb_clk_en     (wb_clk_en),
        .pc_redirect   (pc_redirect),
        .if_flush      (if_flush),
        .id_flush      (id_flush),
        .bus_err       (bus_err),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: age of the outstanding memory access (cycles it has
    // already waited), sticky error flag, stall count.
    int m_age   = 0;
    bit m_err   = 1'b0;
    int m_stall = 0;

    logic [7:0] obs_ctrl;
    assign obs_ctrl = {if_clk_en, id_clk_en, ex_clk_en, mem_clk_en, wb_clk_en,
                       pc_redirect, if_flush, id_flush};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check just after, then advance model.
    task automatic step(input string tag, input logic req, input logic rdy,
                        input logic imem, input logic br, input logic ld,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        logic [7:0] exp_ctrl;
        bit miss, tmo, frz, lu;
        @(negedge clk);
        dmem_req_mem = req; dmem_ready = rdy; imem_ready = imem;
        branch_taken = br; data_rd_en_ex = ld;
        rd0_addr_ex = rd; rs1_addr_id = r1; rs2_addr_id = r2;
        #1;
        miss = req && !rdy;
        tmo  = miss && (m_age == TIMEOUT - 1);
        frz  = miss && !tmo;
        lu   = ld && (rd != 0) && (rd == r1 || rd == r2);
        if (frz)        exp_ctrl = 8'b00000_000;
        else if (lu)    exp_ctrl = 8'b01111_001;
        else if (br)    exp_ctrl = 8'b11111_110;
        else if (!imem) exp_ctrl = 8'b01111_001;
        else            exp_ctrl = 8'b11111_000;
        check({tag, "/ctrl"}, 32'(obs_ctrl), 32'(exp_ctrl));
        check({tag, "/bus_err"}, 32'(bus_err), 32'(m_err));
        check({tag, "/stall"}, 32'(stall_cycles), 32'(m_stall));
        $display("[%0t] %s req=%b rdy=%b imem=%b br=%b lu=%b ctrl=%b err=%b stall=%0d",
                 $time, tag, req, rdy, imem, br, lu, obs_ctrl, bus_err, stall_cycles);
        if (!exp_ctrl[7] && m_stall < CMAX) m_stall++;
        if (frz) m_age++;
        else begin
            m_age = 0;
            if (tmo) m_err = 1'b1;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        // Inputs chosen so that every output would be active without reset.
        imem_ready = 1'b1; branch_taken = 1'b1; dmem_req_mem = 1'b0;
        data_rd_en_ex = 1'b0;
        rst_n = 1'b0;
        #1;
        check({tag, "/rst_ctrl"}, 32'(obs_ctrl), 32'h0);
        check({tag, "/rst_err"}, 32'(bus_err), 32'h0);
        check({tag, "/rst_stall"}, 32'(stall_cycles), 32'h0);
        $display("[%0t] %s reset ctrl=%b err=%b stall=%0d", $time, tag, obs_ctrl, bus_err, stall_cycles);
        m_age = 0; m_err = 1'b0; m_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int s0;
        do_reset("init");

        // 1: load-use on rs1 -> one bubble, then normal
        step("t1_lu",   0, 0, 1, 0, 1, 5'd5, 5'd5, 5'd7);
        check("t1_if_en", 32'(if_clk_en), 32'h0);
        check("t1_idfl",  32'(id_flush),  32'h1);
        step("t1_next", 0, 0, 1, 0, 0, 5'd5, 5'd5, 5'd7);
        check("t1_norm",  32'(obs_ctrl), 32'hF8);

        // 2: load to x0 never stalls
        step("t2_x0",   0, 0, 1, 0, 1, 5'd0, 5'd0, 5'd0);
        check("t2_if_en", 32'(if_clk_en), 32'h1);

        // 3: redirect honoured with imem not ready
        step("t3_br",   0, 0, 0, 1, 0, 5'd0, 5'd1, 5'd2);
        check("t3_redir", 32'({pc_redirect, if_flush}), 32'h3);

        // 4: load-use wins over branch; branch taken next cycle
        step("t4_lu_br", 0, 0, 1, 1, 1, 5'd9, 5'd3, 5'd9);
        check("t4_noredir", 32'({pc_redirect, id_flush}), 32'h1);
        step("t4_br",    0, 0, 1, 1, 0, 5'd9, 5'd3, 5'd9);
        check("t4_redir", 32'(pc_redirect), 32'h1);

        // 5: three wait cycles then completion
        do_reset("t5");
        s0 = m_stall;
        for (int i = 0; i < 3; i++) step("t5_wait", 1, 0, 1, 0, 0, 0, 0, 0);
        step("t5_done", 1, 1, 1, 0, 0, 0, 0, 0);
        step("t5_after", 0, 0, 1, 0, 0, 0, 0, 0);
        check("t5_stall", 32'(stall_cycles), 32'(s0 + 3));
        check("t5_err",   32'(bus_err), 32'h0);

        // 6: timeout, then async reset in the middle of the next wait
        for (int i = 0; i < 3; i++) step("t6_wait", 1, 0, 1, 0, 0, 0, 0, 0);
        step("t6_tmo", 1, 0, 1, 0, 0, 0, 0, 0);
        check("t6_resume", 32'(if_clk_en), 32'h1);
        step("t6_after", 1, 0, 1, 0, 0, 0, 0, 0);
        check("t6_err", 32'(bus_err), 32'h1);
        step("t6_wait2", 1, 0, 1, 0, 0, 0, 0, 0);
        do_reset("t6_midwait");
        step("t6_fresh", 1, 0, 1, 0, 0, 0, 0, 0);
        check("t6_frz", 32'(if_clk_en), 32'h0);

        // stall counter saturation
        for (int i = 0; i < CMAX + 4; i++) step("sat", 0, 0, 0, 0, 0, 0, 0, 0);
        step("sat_chk", 0, 0, 1, 0, 0, 0, 0, 0);
        check("sat_val", 32'(stall_cycles), 32'(CMAX));

        // constrained-random traffic
        for (int i = 0; i < 1200; i++) begin
            logic req, rdy;
            if (i % 300 == 299) do_reset("rnd");
            if (m_age > 0) begin
                req = 1'b1;
                rdy = ($urandom_range(4, 0) < 2);
            end else begin
                req = ($urandom_range(3, 0) == 0);
                rdy = 1'(($urandom & 1) != 0);
            end
            step("rnd", req, rdy, ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) == 0),
                 1'(($urandom & 1) != 0), 5'($urandom_range(3, 0)),
                 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
